// File: rtl/pipe_reg_pkg.sv
// Shared types and helpers for the pipe_reg_chain block.
// Optional occupancy counter is enabled with the PIPE_REG_CHAIN_COUNT_EN macro.
package pipe_reg_pkg;

    // Per-stage handshake view used to build the backward ready chain
    typedef struct packed {
        logic valid;
        logic ready;
    } stage_hs_t;

    // Width of an occupancy counter able to hold 0..depth
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One valid+data register stage with async reset, capture enable and flush.
// Flush clears only the valid bit; the data register keeps its contents.
module pipe_reg_stage
    import pipe_reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             en,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Valid bit: flush wins over capture; a capture may also load a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (en) begin
            valid <= src_valid;
        end
    end

    // Data register: loads only real words, so bubbles never overwrite it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= RESET_VALUE;
        end else if (en && src_valid && !flush) begin
            data <= src_data;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Pipeline register chain: DEPTH handshaked stages with bubble collapsing,
// synchronous flush and configurable data reset value.
// Define PIPE_REG_CHAIN_COUNT_EN to add the registered occupancy counter port.
module pipe_reg_chain
    import pipe_reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_CHAIN_COUNT_EN
    ,
    output logic [cnt_w(DEPTH)-1:0] count
`endif
);

    logic             stage_valid [DEPTH];
    logic [WIDTH-1:0] stage_data  [DEPTH];
    stage_hs_t        hs          [DEPTH];

    // Backward ready chain: a stage can capture if it is empty or its successor can
    always_comb begin
        logic ready_next;
        ready_next = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hs[i].valid = stage_valid[i];
            hs[i].ready = !hs[i].valid || ready_next;
            ready_next  = hs[i].ready;
        end
    end

    assign in_ready  = hs[0].ready && !flush;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = stage_valid[i-1];
            assign src_data  = stage_data[i-1];
        end

        pipe_reg_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .en        (hs[i].ready),
            .src_valid (src_valid),
            .src_data  (src_data),
            .valid     (stage_valid[i]),
            .data      (stage_data[i])
        );
    end

`ifdef PIPE_REG_CHAIN_COUNT_EN
    localparam int CNT_W = cnt_w(DEPTH);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Occupancy tracks the valid bits: up on accept, down on drain, zero on flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (in_fire && !out_fire) begin
            count <= count + CNT_W'(1);
        end else if (out_fire && !in_fire) begin
            count <= count - CNT_W'(1);
        end
    end
`endif

endmodule
